// File: rtl/chacha_keystream_xor.sv
// ChaCha20 keystream buffer: captures a 16-word block and XORs it
// word by word onto a valid/ready data stream.
module chacha_keystream_xor #(
  parameter int CNT_W   = 32,
  parameter int KS_SKIP = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [3:0][3:0][31:0] ks_block,
  input  logic                  ks_valid,
  output logic                  ks_ready,
  output logic                  blk_req,
  input  logic [31:0]           pt_data,
  input  logic [3:0]            pt_keep,
  input  logic                  pt_last,
  input  logic                  pt_valid,
  output logic                  pt_ready,
  output logic [31:0]           ct_data,
  output logic [3:0]            ct_keep,
  output logic                  ct_last,
  output logic                  ct_valid,
  input  logic                  ct_ready,
  output logic [CNT_W-1:0]      blk_count,
  output logic                  done
);

  typedef enum logic [1:0] {
    IDLE, WAIT_KS, STREAM, FLUSH
  } state_t;

  localparam logic [3:0] SKIP = 4'(KS_SKIP);

  state_t          state;
  logic [3:0]      word_idx;
  logic [15:0][31:0] ks_buf;
  logic            first;
  logic            pt_acc;
  logic            ct_acc;
  logic [31:0]     ks_word;
  logic [31:0]     keep_mask;

  assign ks_ready = (state == WAIT_KS);
  assign pt_ready = (state == STREAM) &&
                    (!ct_valid || ct_ready);
  assign pt_acc   = pt_valid && pt_ready;
  assign ct_acc   = ct_valid && ct_ready;
  assign ks_word  = ks_buf[word_idx];
  assign keep_mask = {{8{pt_keep[3]}}, {8{pt_keep[2]}},
                      {8{pt_keep[1]}}, {8{pt_keep[0]}}};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      word_idx  <= '0;
      ks_buf    <= '0;
      first     <= 1'b0;
      blk_count <= '0;
      blk_req   <= 1'b0;
      done      <= 1'b0;
      ct_data   <= '0;
      ct_keep   <= '0;
      ct_last   <= 1'b0;
      ct_valid  <= 1'b0;
    end else begin
      blk_req <= 1'b0;
      done    <= 1'b0;
      if (start) begin
        // abort anything in flight and restart the message
        state     <= WAIT_KS;
        word_idx  <= '0;
        first     <= 1'b1;
        blk_count <= '0;
        blk_req   <= 1'b1;
        ct_data   <= '0;
        ct_keep   <= '0;
        ct_last   <= 1'b0;
        ct_valid  <= 1'b0;
      end else begin
        if (ct_acc)
          ct_valid <= 1'b0;
        if (pt_acc) begin
          ct_data  <= (pt_data ^ ks_word) & keep_mask;
          ct_keep  <= pt_keep;
          ct_last  <= pt_last;
          ct_valid <= 1'b1;
          word_idx <= word_idx + 4'd1;
        end
        unique case (state)
          IDLE: ;
          WAIT_KS: begin
            if (ks_valid) begin
              ks_buf    <= ks_block;
              blk_count <= blk_count + 1'b1;
              word_idx  <= first ? SKIP : 4'd0;
              first     <= 1'b0;
              state     <= STREAM;
            end
          end
          STREAM: begin
            if (pt_acc) begin
              if (pt_last) begin
                state <= FLUSH;
              end else if (word_idx == 4'd15) begin
                blk_req <= 1'b1;
                state   <= WAIT_KS;
              end
            end
          end
          FLUSH: begin
            if (ct_acc && ct_last) begin
              done  <= 1'b1;
              state <= IDLE;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_chacha_keystream_xor.sv
// Directed bench for chacha_keystream_xor: table of messages plus
// abort, skip and async-reset sequences.
module tb_chacha_keystream_xor;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                  rst, start;
  logic [3:0][3:0][31:0] ks_block;
  logic                  ks_valid;
  logic [31:0]           pt_data;
  logic [3:0]            pt_keep;
  logic                  pt_last, pt_valid;
  logic                  ct_ready;

  logic        ks_ready, blk_req, pt_ready;
  logic [31:0] ct_data;
  logic [3:0]  ct_keep;
  logic        ct_last, ct_valid, done;
  logic [31:0] blk_count;

  logic        ks_ready1, blk_req1, pt_ready1;
  logic [31:0] ct_data1;
  logic [3:0]  ct_keep1;
  logic        ct_last1, ct_valid1, done1;
  logic [31:0] blk_count1;

  chacha_keystream_xor #(.CNT_W(32), .KS_SKIP(0)) dut (
    .clk(clk), .rst(rst), .start(start),
    .ks_block(ks_block), .ks_valid(ks_valid),
    .ks_ready(ks_ready), .blk_req(blk_req),
    .pt_data(pt_data), .pt_keep(pt_keep),
    .pt_last(pt_last), .pt_valid(pt_valid),
    .pt_ready(pt_ready), .ct_data(ct_data),
    .ct_keep(ct_keep), .ct_last(ct_last),
    .ct_valid(ct_valid), .ct_ready(ct_ready),
    .blk_count(blk_count), .done(done)
  );

  chacha_keystream_xor #(.CNT_W(32), .KS_SKIP(1)) dut1 (
    .clk(clk), .rst(rst), .start(start),
    .ks_block(ks_block), .ks_valid(ks_valid),
    .ks_ready(ks_ready1), .blk_req(blk_req1),
    .pt_data(pt_data), .pt_keep(pt_keep),
    .pt_last(pt_last), .pt_valid(pt_valid),
    .pt_ready(pt_ready1), .ct_data(ct_data1),
    .ct_keep(ct_keep1), .ct_last(ct_last1),
    .ct_valid(ct_valid1), .ct_ready(ct_ready),
    .blk_count(blk_count1), .done(done1)
  );

  typedef struct {
    logic [31:0] d;
    logic [3:0]  k;
    logic        l;
  } beat_t;

  typedef struct {
    int          n;
    logic [31:0] base;
    logic [31:0] step;
    logic [3:0]  klast;
    bit          rnd;
    int          req;
    int          cnt;
  } vec_t;

  int    errors = 0;
  int    checks = 0;
  int    nblk, nreq, ndone, stab_bad;
  beat_t q[$];
  beat_t q1[$];
  logic [36:0] held;
  logic        hold_v;
  bit    rnd, ct_force, rnd_bit;

  function automatic logic [31:0] ksw(input int k, input int w);
    logic [31:0] a, b;
    a = w;
    b = k;
    return (a * 32'h0101_0101) ^ (b * 32'h1357_9BDF);
  endfunction

  function automatic logic [31:0] kmask(input logic [3:0] k);
    return {{8{k[3]}}, {8{k[2]}}, {8{k[1]}}, {8{k[0]}}};
  endfunction

  always_comb begin
    ks_block = '0;
    for (int i = 0; i < 16; i++)
      ks_block[i/4][i%4] = ksw(nblk, i);
  end

  assign ct_ready = rnd ? rnd_bit : ct_force;

  always @(negedge clk) rnd_bit <= 1'($urandom_range(0, 1));

  initial begin
    nblk = 0; nreq = 0; ndone = 0; stab_bad = 0;
    hold_v = 1'b0; held = '0;
  end

  always @(posedge clk) begin
    if (start) begin
      nblk  <= 0;
      nreq  <= 0;
      ndone <= 0;
      q.delete();
      q1.delete();
    end else begin
      if (ks_valid && ks_ready) nblk <= nblk + 1;
      if (blk_req) nreq <= nreq + 1;
      if (done) ndone <= ndone + 1;
      if (ct_valid && ct_ready)
        q.push_back('{ct_data, ct_keep, ct_last});
      if (ct_valid1 && ct_ready)
        q1.push_back('{ct_data1, ct_keep1, ct_last1});
    end
    if (hold_v && ct_valid && held != {ct_data, ct_keep, ct_last})
      stab_bad <= stab_bad + 1;
    hold_v <= ct_valid && !ct_ready;
    held   <= {ct_data, ct_keep, ct_last};
  end

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send(input int n, input logic [31:0] base,
                      input logic [31:0] step, input logic [3:0] klast,
                      input bit lst);
    for (int i = 0; i < n; i++) begin
      int g;
      bit ok;
      pt_valid = 1'b1;
      pt_data  = base + i * step;
      pt_last  = lst && (i == n - 1);
      pt_keep  = (i == n - 1) ? klast : 4'hF;
      g = 0;
      ok = 1'b0;
      while (!ok && g < 300) begin
        #1;
        ok = pt_ready;
        @(negedge clk);
        g++;
      end
      checks++;
      if (!ok) begin
        errors++;
        $display("FAIL send_stall beat %0d: pt_ready 0 required 1", i);
        break;
      end
    end
    pt_valid = 1'b0;
    pt_last  = 1'b0;
  endtask

  task automatic wait_done();
    int g;
    g = 0;
    while (ndone == 0 && g < 400) begin
      @(negedge clk);
      g++;
    end
    chk("done_seen", 64'(ndone != 0), 64'd1);
    rnd = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  vec_t vt[6];

  initial begin
    rst = 1'b1; start = 1'b0; ks_valid = 1'b1;
    pt_data = '0; pt_keep = 4'hF; pt_last = 1'b0; pt_valid = 1'b0;
    rnd = 1'b0; ct_force = 1'b1;

    vt[0] = '{16, 32'h0000_0000, 32'h0000_0000, 4'hF, 1'b0, 1, 1};
    vt[1] = '{20, 32'hFFFF_FFFF, 32'h0000_0000, 4'hF, 1'b0, 2, 2};
    vt[2] = '{16, 32'h1234_5678, 32'h1111_1111, 4'hF, 1'b1, 1, 1};
    vt[3] = '{5,  32'hA5A5_A5A5, 32'h0000_0003, 4'h3, 1'b0, 1, 1};
    vt[4] = '{32, 32'h0000_0000, 32'h0000_0001, 4'hF, 1'b1, 2, 2};
    vt[5] = '{33, 32'hDEAD_BEEF, 32'h0000_0007, 4'h1, 1'b0, 3, 3};

    repeat (2) @(negedge clk);
    chk("reset_ctl", 64'({ks_ready, pt_ready, blk_req, ct_valid,
                          ct_last, done, ct_keep}), 64'd0);
    chk("reset_data", 64'({ct_data, blk_count}), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    for (int v = 0; v < 6; v++) begin
      rnd = vt[v].rnd;
      pulse_start();
      send(vt[v].n, vt[v].base, vt[v].step, vt[v].klast, 1'b1);
      wait_done();
      chk($sformatf("v%0d_beats", v), 64'(q.size()), 64'(vt[v].n));
      for (int j = 0; j < vt[v].n && j < q.size(); j++) begin
        logic [31:0] pt, ed;
        logic [3:0]  ek;
        pt = vt[v].base + j * vt[v].step;
        ek = (j == vt[v].n - 1) ? vt[v].klast : 4'hF;
        ed = (pt ^ ksw(j / 16, j % 16)) & kmask(ek);
        chk($sformatf("v%0d_beat%0d", v, j),
            64'({q[j].d, q[j].k, q[j].l}),
            64'({ed, ek, j == vt[v].n - 1}));
      end
      chk($sformatf("v%0d_blk_req", v), 64'(nreq), 64'(vt[v].req));
      chk($sformatf("v%0d_blk_count", v), 64'(blk_count),
          64'(vt[v].cnt));
      chk($sformatf("v%0d_done_once", v), 64'(ndone), 64'd1);
      chk($sformatf("v%0d_stable", v), 64'(stab_bad), 64'd0);
    end

    // abort mid-stream with a beat pending on the output
    pulse_start();
    send(7, 32'h0, 32'h0, 4'hF, 1'b0);
    ct_force = 1'b0;
    #1;
    chk("abort_pending", 64'(ct_valid), 64'd1);
    pulse_start();
    chk("abort_ct_valid", 64'(ct_valid), 64'd0);
    chk("abort_blk_req", 64'(blk_req), 64'd1);
    ct_force = 1'b1;
    send(2, 32'h0, 32'h0, 4'hF, 1'b1);
    wait_done();
    chk("abort_beats", 64'(q.size()), 64'd2);
    if (q.size() == 2) begin
      chk("abort_w0", 64'(q[0].d), 64'(ksw(0, 0)));
      chk("abort_w1", 64'(q[1].d), 64'h0101_0101);
    end
    chk("abort_req", 64'(nreq), 64'd1);
    chk("abort_cnt", 64'(blk_count), 64'd1);
    chk("skip_beats", 64'(q1.size()), 64'd2);
    if (q1.size() == 2) begin
      chk("skip_w0", 64'(q1[0].d), 64'h0101_0101);
      chk("skip_w1", 64'(q1[1].d), 64'h0202_0202);
    end

    // asynchronous reset mid-message
    pulse_start();
    send(5, 32'h5555_0000, 32'h1, 4'hF, 1'b0);
    ct_force = 1'b0;
    #1;
    chk("pre_rst_valid", 64'(ct_valid), 64'd1);
    #1;
    rst = 1'b1;
    #1;
    chk("arst_ctl", 64'({ks_ready, pt_ready, blk_req, ct_valid,
                         ct_last, done, ct_keep}), 64'd0);
    chk("arst_data", 64'({ct_data, blk_count}), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    ct_force = 1'b1;
    repeat (2) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
